iopmp_err_capture: RTL and testbench

Error capture stage directly downstream of the IOPMP array checker. It consumes the per-channel combinational error reports and records the first violation into a held error record for software. Simultaneous violations are arbitrated round-robin. Later violations are counted and flagged as subsequent violations without overwriting the record. The record is held until software clears it, and a level interrupt is raised while a record is valid.

---
 rtl/iopmp_err_capture.sv | 204 ++++++++++++++++++++
 tb/tb_iopmp_err_capture.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iopmp_err_capture.sv
// iopmp_err_capture: holds the first IOPMP violation for software, with
// round-robin arbitration of simultaneous hits and a saturating count of
// violations that arrive while a record is held.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   iopmp_req_valid_i     per-channel request valid
//   iopmp_error_report    per-channel checker report
//   intr_en_i             interrupt enable (gates irq_o only)
//   err_clear_i           write-1-to-clear pulse
//   err_*_o               held record, svc flag and counter
//   irq_o                 err_valid_o & intr_en_i
package iopmp_pkg;

  localparam int unsigned SourceWidth = 4;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_ILL_READ  = 3'd1,
    ERR_ILL_WRITE = 3'd2,
    ERR_ILL_EXEC  = 3'd3,
    ERR_PARTIAL   = 3'd4,
    ERR_NO_HIT    = 3'd5
  } error_type;

  typedef enum logic [1:0] {
    TT_NONE  = 2'd0,
    TT_READ  = 2'd1,
    TT_WRITE = 2'd2,
    TT_EXEC  = 2'd3
  } transaction_type;

  typedef struct packed {
    logic [SourceWidth-1:0] rrid;
    logic [7:0]             eid;
  } err_reqid_t;

  typedef struct packed {
    logic            iopmp_fail;
    error_type       etype;
    transaction_type ttype;
    logic [33:0]     ERR_REQADDR;
    err_reqid_t      ERR_REQID;
  } error_report_t;

endpackage

module iopmp_err_capture
  import iopmp_pkg::*;
#(
  parameter int unsigned IOPMPNumChan = 4,
  parameter int unsigned CntWidth     = 8,
  localparam int unsigned ChanW =
    (IOPMPNumChan > 1) ? $clog2(IOPMPNumChan) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IOPMPNumChan-1:0]      iopmp_req_valid_i,
  input  error_report_t [IOPMPNumChan-1:0] iopmp_error_report,
  input  logic                         intr_en_i,
  input  logic                         err_clear_i,
  output logic                         err_valid_o,
  output logic [ChanW-1:0]             err_chan_o,
  output error_type                    err_etype_o,
  output transaction_type              err_ttype_o,
  output logic [33:0]                  err_addr_o,
  output logic [SourceWidth-1:0]       err_rrid_o,
  output logic [7:0]                   err_eid_o,
  output logic                         err_svc_o,
  output logic [CntWidth-1:0]          err_svc_cnt_o,
  output logic                         irq_o
);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_e;

  localparam logic [ChanW:0] NumChan = (ChanW+1)'(IOPMPNumChan);

  state_e                 state_q, state_d;
  logic [ChanW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ChanW-1:0]       chan_q, chan_d;
  error_type              etype_q, etype_d;
  transaction_type        ttype_q, ttype_d;
  logic [33:0]            addr_q, addr_d;
  logic [SourceWidth-1:0] rrid_q, rrid_d;
  logic [7:0]             eid_q, eid_d;
  logic                   svc_q, svc_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;

  logic [IOPMPNumChan-1:0] hit;
  logic                    any_hit;
  logic                    sel_found;
  logic [ChanW-1:0]        sel_idx;
  logic [ChanW:0]          cand;
  logic                    capture;

  always_comb begin
    for (int j = 0; j < int'(IOPMPNumChan); j++) begin
      hit[j] = iopmp_req_valid_i[j] & iopmp_error_report[j].iopmp_fail;
    end
    any_hit = |hit;
  end

  // Round-robin: first hit at or above rr_ptr, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < int'(IOPMPNumChan); i++) begin
      cand = {1'b0, rr_ptr_q} + (ChanW+1)'(i);
      if (cand >= NumChan) cand = cand - NumChan;
      if (!sel_found && hit[cand[ChanW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[ChanW-1:0];
      end
    end
  end

  // A clear in HELD reopens the record in the same cycle so a coincident
  // hit is captured rather than lost.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    chan_d   = chan_q;
    etype_d  = etype_q;
    ttype_d  = ttype_q;
    addr_d   = addr_q;
    rrid_d   = rrid_q;
    eid_d    = eid_q;
    svc_d    = svc_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;

    unique case (state_q)
      IDLE: begin
        capture = any_hit;
      end
      HELD: begin
        if (err_clear_i) begin
          svc_d   = 1'b0;
          cnt_d   = '0;
          capture = any_hit;
          if (!any_hit) state_d = IDLE;
        end else if (any_hit) begin
          svc_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture && sel_found) begin
      state_d  = HELD;
      chan_d   = sel_idx;
      etype_d  = iopmp_error_report[sel_idx].etype;
      ttype_d  = iopmp_error_report[sel_idx].ttype;
      addr_d   = iopmp_error_report[sel_idx].ERR_REQADDR;
      rrid_d   = iopmp_error_report[sel_idx].ERR_REQID.rrid;
      eid_d    = iopmp_error_report[sel_idx].ERR_REQID.eid;
      if ({1'b0, sel_idx} == NumChan - 1'b1) rr_ptr_d = '0;
      else rr_ptr_d = sel_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      chan_q   <= '0;
      etype_q  <= ERR_NONE;
      ttype_q  <= TT_NONE;
      addr_q   <= '0;
      rrid_q   <= '0;
      eid_q    <= '0;
      svc_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      chan_q   <= chan_d;
      etype_q  <= etype_d;
      ttype_q  <= ttype_d;
      addr_q   <= addr_d;
      rrid_q   <= rrid_d;
      eid_q    <= eid_d;
      svc_q    <= svc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign err_valid_o   = (state_q == HELD);
  assign err_chan_o    = chan_q;
  assign err_etype_o   = etype_q;
  assign err_ttype_o   = ttype_q;
  assign err_addr_o    = addr_q;
  assign err_rrid_o    = rrid_q;
  assign err_eid_o     = eid_q;
  assign err_svc_o     = svc_q;
  assign err_svc_cnt_o = cnt_q;
  assign irq_o         = err_valid_o & intr_en_i;

endmodule

// File: tb/tb_iopmp_err_capture.sv
// Bench for iopmp_err_capture: table vectors, directed corner sequences
// and randomized traffic against a behavioural model.
module tb_iopmp_err_capture;
  import iopmp_pkg::*;

  localparam int N    = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           vld;
  error_report_t [N-1:0]  rep;
  logic                   ien;
  logic                   clr;
  logic                   ev;
  logic [1:0]             ech;
  error_type              eet;
  transaction_type        ett;
  logic [33:0]            eaddr;
  logic [SourceWidth-1:0] errid;
  logic [7:0]             eeid;
  logic                   esvc;
  logic [CW-1:0]          ecnt;
  logic                   irq;

  iopmp_err_capture #(.IOPMPNumChan(N), .CntWidth(CW)) dut (
    .clk                (clk),
    .rst                (rst),
    .iopmp_req_valid_i  (vld),
    .iopmp_error_report (rep),
    .intr_en_i          (ien),
    .err_clear_i        (clr),
    .err_valid_o        (ev),
    .err_chan_o         (ech),
    .err_etype_o        (eet),
    .err_ttype_o        (ett),
    .err_addr_o         (eaddr),
    .err_rrid_o         (errid),
    .err_eid_o          (eeid),
    .err_svc_o          (esvc),
    .err_svc_cnt_o      (ecnt),
    .irq_o              (irq)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Behavioural model
  bit            m_valid;
  int            m_chan;
  error_report_t m_rec;
  bit            m_svc;
  int            m_cnt;
  int            m_rr;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic void model_reset();
    m_valid = 0;
    m_chan  = 0;
    m_rec   = '0;
    m_svc   = 0;
    m_cnt   = 0;
    m_rr    = 0;
  endfunction

  function automatic void model_step();
    bit h [N];
    bit any = 0;
    for (int j = 0; j < N; j++) begin
      h[j] = vld[j] && rep[j].iopmp_fail;
      if (h[j]) any = 1;
    end
    if (m_valid && !clr) begin
      if (any) begin
        m_svc = 1;
        if (m_cnt < CMAX) m_cnt++;
      end
    end else begin
      if (m_valid) begin
        m_valid = 0;
        m_svc   = 0;
        m_cnt   = 0;
      end
      for (int off = 0; off < N; off++) begin
        int c = (m_rr + off) % N;
        if (h[c]) begin
          m_valid = 1;
          m_chan  = c;
          m_rec   = rep[c];
          m_rr    = (c + 1) % N;
          break;
        end
      end
    end
  endfunction

  task automatic check_model(string tag);
    chk({tag, ".valid"}, 64'(ev), 64'(m_valid));
    chk({tag, ".chan"}, 64'(ech), 64'(m_chan));
    chk({tag, ".etype"}, 64'(eet), 64'(m_rec.etype));
    chk({tag, ".ttype"}, 64'(ett), 64'(m_rec.ttype));
    chk({tag, ".addr"}, 64'(eaddr), 64'(m_rec.ERR_REQADDR));
    chk({tag, ".rrid"}, 64'(errid), 64'(m_rec.ERR_REQID.rrid));
    chk({tag, ".eid"}, 64'(eeid), 64'(m_rec.ERR_REQID.eid));
    chk({tag, ".svc"}, 64'(esvc), 64'(m_svc));
    chk({tag, ".cnt"}, 64'(ecnt), 64'(m_cnt));
    chk({tag, ".irq"}, 64'(irq), 64'(m_valid && ien));
  endtask

  task automatic default_reports();
    for (int j = 0; j < N; j++) begin
      rep[j].iopmp_fail          = 1'b0;
      rep[j].etype               = error_type'(3'(j + 1));
      rep[j].ttype               = transaction_type'(2'(j));
      rep[j].ERR_REQADDR         = 34'h0_1000_0000 + 34'(j * 64);
      rep[j].ERR_REQID.rrid      = SourceWidth'(j);
      rep[j].ERR_REQID.eid       = 8'(j + 16);
    end
  endtask

  task automatic drive(logic [N-1:0] v, logic [N-1:0] f, logic c, logic ie);
    vld = v;
    clr = c;
    ien = ie;
    for (int j = 0; j < N; j++) rep[j].iopmp_fail = f[j];
  endtask

  // Inputs change 1 time unit after the edge; outputs are checked then too.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] f;
    logic         c;
    logic         ie;
    logic         e_v;
    int           e_ch;
    logic         e_svc;
    int           e_cnt;
    logic         e_irq;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{4'b0000, 4'b1111, 0, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{4'b1001, 4'b1001, 0, 1, 1, 0, 0, 0, 1};
    tbl[2] = '{4'b0100, 4'b0100, 0, 1, 1, 0, 1, 1, 1};
    tbl[3] = '{4'b1111, 4'b1111, 0, 1, 1, 0, 1, 2, 1};
    tbl[4] = '{4'b0000, 4'b0000, 1, 1, 0, 0, 0, 0, 0};
    tbl[5] = '{4'b1001, 4'b1001, 0, 1, 1, 3, 0, 0, 1};
    tbl[6] = '{4'b0000, 4'b0000, 0, 0, 1, 3, 0, 0, 0};
    tbl[7] = '{4'b0010, 4'b0010, 1, 1, 1, 1, 0, 0, 1};
    tbl[8] = '{4'b0011, 4'b0011, 0, 1, 1, 1, 1, 1, 1};
    tbl[9] = '{4'b0001, 4'b0000, 1, 1, 0, 1, 0, 0, 0};

    vld = '0;
    ien = 1'b0;
    clr = 1'b0;
    rep = '0;
    default_reports();
    do_reset();

    // reset state
    chk("rst.valid", 64'(ev), 0);
    chk("rst.irq", 64'(irq), 0);
    chk("rst.addr", 64'(eaddr), 0);
    chk("rst.cnt", 64'(ecnt), 0);

    // table vectors from reset
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].f, tbl[i].c, tbl[i].ie);
      cycle();
      chk($sformatf("tbl%0d.valid", i), 64'(ev), 64'(tbl[i].e_v));
      chk($sformatf("tbl%0d.chan", i), 64'(ech), 64'(tbl[i].e_ch));
      chk($sformatf("tbl%0d.svc", i), 64'(esvc), 64'(tbl[i].e_svc));
      chk($sformatf("tbl%0d.cnt", i), 64'(ecnt), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d.irq", i), 64'(irq), 64'(tbl[i].e_irq));
    end

    // single error on channel 2
    do_reset();
    rep[2].ERR_REQADDR    = 34'h1_0000_0040;
    rep[2].ERR_REQID.rrid = 4'd3;
    rep[2].ERR_REQID.eid  = 8'd5;
    drive(4'b0100, 4'b0100, 0, 1);
    cycle();
    drive(4'b0000, 4'b0000, 0, 1);
    chk("single.valid", 64'(ev), 1);
    chk("single.chan", 64'(ech), 2);
    chk("single.addr", 64'(eaddr), 64'h1_0000_0040);
    chk("single.rrid", 64'(errid), 3);
    chk("single.eid", 64'(eeid), 5);
    chk("single.irq", 64'(irq), 1);
    chk("single.svc", 64'(esvc), 0);

    // saturation: 300 hit cycles while held
    for (int i = 0; i < 300; i++) begin
      drive(4'($urandom_range(1, 15)), 4'b1111, 0, 1);
      cycle();
      if (i == 253) chk("sat.cnt254", 64'(ecnt), 254);
      if (i == 254) chk("sat.cnt255", 64'(ecnt), 255);
    end
    drive(4'b0000, 4'b0000, 0, 1);
    chk("sat.cnt", 64'(ecnt), 255);
    chk("sat.svc", 64'(esvc), 1);
    chk("sat.chan", 64'(ech), 2);
    chk("sat.addr", 64'(eaddr), 64'h1_0000_0040);

    // clear collides with a channel 1 hit at count 4
    default_reports();
    drive(4'b0000, 4'b0000, 1, 1);
    cycle();
    drive(4'b0001, 4'b0001, 0, 1);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(4'b1000, 4'b1000, 0, 1);
      cycle();
    end
    chk("coll.cnt4", 64'(ecnt), 4);
    drive(4'b0010, 4'b0010, 1, 1);
    cycle();
    drive(4'b0000, 4'b0000, 0, 1);
    chk("coll.valid", 64'(ev), 1);
    chk("coll.chan", 64'(ech), 1);
    chk("coll.svc", 64'(esvc), 0);
    chk("coll.cnt", 64'(ecnt), 0);

    // fail without valid is ignored, held or idle
    drive(4'b0000, 4'b1111, 0, 1);
    cycle();
    chk("nov.held_cnt", 64'(ecnt), 0);
    drive(4'b0000, 4'b1111, 1, 1);
    cycle();
    cycle();
    chk("nov.idle_valid", 64'(ev), 0);

    // interrupt gating
    drive(4'b1000, 4'b1000, 0, 0);
    cycle();
    drive(4'b0000, 4'b0000, 0, 0);
    chk("ien.valid", 64'(ev), 1);
    chk("ien.irq_off", 64'(irq), 0);
    ien = 1'b1;
    #1;
    chk("ien.irq_on", 64'(irq), 1);
    ien = 1'b0;
    #1;
    chk("ien.irq_drop", 64'(irq), 0);

    // reset mid-HELD, rr pointer returns to 0
    ien = 1'b1;
    drive(4'b0000, 4'b0000, 1, 1);
    cycle();
    drive(4'b0001, 4'b0001, 0, 1);
    cycle();
    drive(4'b0000, 4'b0000, 0, 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("mrst.valid", 64'(ev), 0);
    chk("mrst.irq", 64'(irq), 0);
    chk("mrst.chan", 64'(ech), 0);
    chk("mrst.addr", 64'(eaddr), 0);
    #2;
    rst = 1'b0;
    drive(4'b0011, 4'b0011, 0, 1);
    cycle();
    drive(4'b0000, 4'b0000, 0, 1);
    chk("mrst.cap_valid", 64'(ev), 1);
    chk("mrst.cap_chan", 64'(ech), 0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic [N-1:0] v;
      v = 4'($urandom);
      if ($urandom_range(0, 2) == 0) v = '0;
      for (int j = 0; j < N; j++) begin
        rep[j].etype          = error_type'(3'($urandom_range(0, 5)));
        rep[j].ttype          = transaction_type'(2'($urandom));
        rep[j].ERR_REQADDR    = {2'($urandom), 32'($urandom)};
        rep[j].ERR_REQID.rrid = SourceWidth'($urandom);
        rep[j].ERR_REQID.eid  = 8'($urandom);
      end
      drive(v, 4'($urandom), $urandom_range(0, 5) == 0, 1'($urandom));
      cycle();
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
